mem_port_arb_ctrl: RTL and testbench
====================================

Name: mem_port_arb_ctrl

Overview:
- Shared-memory port controller that consumes the one-hot grant from the round-robin arbiter.
- Sits between N requesters (e.g. IF fetch port, LSU data port) and a single memory port.
- Forwards requests to the arbiter, latches the granted request, issues it to memory with a valid/ready handshake, waits for the response, and routes it back to the owning requester.
- Exactly one transaction is outstanding at a time.

Parameters:
- N, 2, number of requester ports
- AW, 32, address width
- DW, 32, data width; byte-strobe width is DW/8

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- port_req_valid  in  N  per-port request valid
- port_req_ready  out  N  per-port accept; one-hot or zero
- port_req_addr  in  N*AW  flattened; port i occupies [i*AW +: AW]
- port_req_we  in  N  per-port write enable
- port_req_wdata  in  N*DW  flattened write data
- port_req_wstrb  in  N*DW/8  flattened byte strobes
- port_rsp_valid  out  N  per-port response valid; one-hot or zero
- port_rsp_rdata  out  DW  shared response data, qualified by port_rsp_valid
- arb_req  out  N  request vector to arbiter
- arb_grant  in  N  one-hot grant from arbiter, combinational from arb_req
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory request accept
- mem_req_addr  out  AW  memory address
- mem_req_we  out  1  memory write enable
- mem_req_wdata  out  DW  memory write data
- mem_req_wstrb  out  DW/8  memory byte strobes
- mem_rsp_valid  in  1  memory response, one per accepted request (reads and writes)
- mem_rsp_rdata  in  DW  memory response data

Behaviour:
- FSM states: IDLE, ISSUE, WAIT.
- Reset (rstn=0 at posedge):
  - State goes to IDLE; owner and latched fields go to 0.
  - port_rsp_valid=0, port_rsp_rdata=0, mem_req_valid=0.
  - Any in-flight transaction is dropped; a later mem_rsp_valid is ignored.
- arb_req = port_req_valid in IDLE, 0 in ISSUE/WAIT.
  - Gating keeps arbiter fairness state frozen while busy.
- IDLE:
  - sel = arb_grant & port_req_valid.
  - port_req_ready = sel (combinational).
  - If sel is nonzero: latch owner index (onehot-to-binary), addr, we, wdata, wstrb of that port; go to ISSUE.
  - sel with more than one bit set: treat as protocol error; take the lowest set bit; assertion fires in simulation.
- ISSUE:
  - mem_req_valid=1; mem_req_* driven from latched registers and held stable until accepted.
  - On mem_req_ready, go to WAIT.
- WAIT:
  - On mem_rsp_valid: register mem_rsp_rdata into port_rsp_rdata; set port_rsp_valid[owner]=1 on the next cycle; go to IDLE.
- port_rsp_valid is a single-cycle pulse. port_rsp_rdata holds its value until the next response.
- mem_rsp_valid in IDLE or ISSUE is ignored.
- A new grant may be taken in the same cycle that port_rsp_valid pulses, since that cycle is already IDLE.
- Latency (accept at cycle T, mem_req_ready=1 at T+1, mem_rsp_valid at cycle R):
  - mem_req_valid asserted at T+1.
  - port_rsp_valid at R+1.
  - Minimum round trip, with R=T+2: 3 cycles accept-to-response.
- The requester must not change its request between valid and ready (standard valid/ready); after ready its fields are don't-care.
- Non-granted ports see port_req_ready=0 and must hold valid.

Decomposition:
- mem_arb_pkg: state enum (IDLE/ISSUE/WAIT, 2-bit), default AW/DW localparams, and the struct {addr, we, wdata, wstrb} used for the latched request.
- One sub-module, onehot_to_bin #(N): combinational one-hot to $clog2(N) index, lowest set bit wins, plus an onehot_err output.
- The arbiter is instantiated beside this block at the next level up, not inside it.

Test Plan:
- Single read, port 0: addr=0x100, mem_req_ready=1 immediately, mem_rsp at accept+2 with rdata=0xDEADBEEF -> port_req_ready[0] at T; mem_req_addr=0x100 at T+1; port_rsp_valid=2'b01 with rdata 0xDEADBEEF at T+3.
- Both ports valid continuously, 4 transactions -> owners alternate 0,1,0,1 (given arbiter grants); arb_req=0 throughout ISSUE/WAIT.
- Backpressure: mem_req_ready low for 5 cycles, port 1 write addr=0x200, wdata=0x12345678, wstrb=4'b0011 -> mem_req_* stable for all 5 cycles; transfer occurs on the cycle ready rises.
- Spurious mem_rsp_valid in IDLE and in ISSUE -> no port_rsp_valid; state unchanged.
- rstn low for 1 cycle during WAIT -> next cycle state IDLE with all outputs 0; subsequent late mem_rsp_valid ignored; a new request is accepted normally.
- Back-to-back: port 0 valid while a response is pulsing to port 1 -> port_req_ready[0] in the same cycle as port_rsp_valid[1].

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port controller: FSM state, default widths,
// and the latched request record.
package mem_arb_pkg;

    localparam int MEM_AW = 32;
    localparam int MEM_DW = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    typedef struct packed {
        logic [MEM_AW-1:0]   addr;
        logic                we;
        logic [MEM_DW-1:0]   wdata;
        logic [MEM_DW/8-1:0] wstrb;
    } mem_req_t;

endpackage

// File: rtl/mem_port_arb_ctrl_if.sv
// Single memory port: request valid/ready handshake plus response strobe.
interface mem_port_if
    import mem_arb_pkg::*;
#(
    parameter int AW = MEM_AW,
    parameter int DW = MEM_DW
);
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [AW-1:0]     mem_req_addr;
    logic              mem_req_we;
    logic [DW-1:0]     mem_req_wdata;
    logic [DW/8-1:0]   mem_req_wstrb;
    logic              mem_rsp_valid;
    logic [DW-1:0]     mem_rsp_rdata;

    modport master (
        output mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, mem_req_wstrb,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, mem_req_wstrb,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
    );
endinterface

// File: rtl/mem_port_arb_ctrl_onehot_to_bin.sv
// One-hot to binary index; lowest set bit wins, err flags more than one bit.
module onehot_to_bin #(
    parameter int  N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  onehot,
    output logic [N-1:0]  lsb,
    output logic [IW-1:0] idx,
    output logic          err
);
    always_comb begin
        idx = '0;
        lsb = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (onehot[i]) begin
                idx    = IW'(i);
                lsb    = '0;
                lsb[i] = 1'b1;
            end
        end
    end

    assign err = |(onehot & (onehot - N'(1)));
endmodule

// File: rtl/mem_port_arb_ctrl.sv
// Shares one memory port among N requesters: takes the arbiter grant,
// issues one transaction at a time and routes the response back to its owner.
//
//   state    | meaning
//   ST_IDLE  | arbiter sees requests; a granted request is latched
//   ST_ISSUE | latched request driven on the memory port until accepted
//   ST_WAIT  | waiting for the single memory response
module mem_port_arb_ctrl
    import mem_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int AW = MEM_AW,
    parameter int DW = MEM_DW
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [N-1:0]      port_req_valid,
    output logic [N-1:0]      port_req_ready,
    input  logic [N*AW-1:0]   port_req_addr,
    input  logic [N-1:0]      port_req_we,
    input  logic [N*DW-1:0]   port_req_wdata,
    input  logic [N*DW/8-1:0] port_req_wstrb,
    output logic [N-1:0]      port_rsp_valid,
    output logic [DW-1:0]     port_rsp_rdata,
    output logic [N-1:0]      arb_req,
    input  logic [N-1:0]      arb_grant,
    mem_port_if.master        mem
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int SW = DW / 8;

    state_e          state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    mem_req_t        req_q, req_d, granted;
    logic            mem_req_valid_q, mem_req_valid_d;
    logic [N-1:0]    rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;

    logic [N-1:0]    sel, sel_lsb;
    logic [IW-1:0]   sel_idx;
    logic            sel_err;
    logic            idle;

    assign idle = (state_q == ST_IDLE);
    // Requests are hidden from the arbiter while busy so its fairness pointer stays put.
    assign arb_req        = idle ? port_req_valid : '0;
    assign sel            = idle ? (arb_grant & port_req_valid) : '0;
    assign port_req_ready = sel_lsb;

    onehot_to_bin #(.N(N)) u_onehot_to_bin (
        .onehot (sel),
        .lsb    (sel_lsb),
        .idx    (sel_idx),
        .err    (sel_err)
    );

    always_comb begin
        granted = '0;
        for (int i = 0; i < N; i++) begin
            if (sel_lsb[i]) begin
                granted.addr  = port_req_addr[i*AW +: AW];
                granted.we    = port_req_we[i];
                granted.wdata = port_req_wdata[i*DW +: DW];
                granted.wstrb = port_req_wstrb[i*SW +: SW];
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        req_d           = req_q;
        mem_req_valid_d = mem_req_valid_q;
        rsp_valid_d     = '0;
        rsp_rdata_d     = rsp_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (|sel_lsb) begin
                    state_d         = ST_ISSUE;
                    owner_d         = sel_idx;
                    req_d           = granted;
                    mem_req_valid_d = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (mem.mem_req_ready) begin
                    state_d         = ST_WAIT;
                    mem_req_valid_d = 1'b0;
                end
            end
            ST_WAIT: begin
                if (mem.mem_rsp_valid) begin
                    state_d              = ST_IDLE;
                    rsp_rdata_d          = mem.mem_rsp_rdata;
                    rsp_valid_d[owner_q] = 1'b1;
                end
            end
            default: begin
                state_d         = ST_IDLE;
                mem_req_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q         <= ST_IDLE;
            owner_q         <= '0;
            req_q           <= '0;
            mem_req_valid_q <= 1'b0;
            rsp_valid_q     <= '0;
            rsp_rdata_q     <= '0;
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            req_q           <= req_d;
            mem_req_valid_q <= mem_req_valid_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_rdata_q     <= rsp_rdata_d;
        end
    end

    assign mem.mem_req_valid = mem_req_valid_q;
    assign mem.mem_req_addr  = req_q.addr;
    assign mem.mem_req_we    = req_q.we;
    assign mem.mem_req_wdata = req_q.wdata;
    assign mem.mem_req_wstrb = req_q.wstrb;
    assign port_rsp_valid    = rsp_valid_q;
    assign port_rsp_rdata    = rsp_rdata_q;

    // A multi-bit grant is an upstream fault; the lowest port still wins.
    a_single_grant: assert property (@(posedge clk) disable iff (!rstn) !sel_err);
endmodule

// File: tb/tb_mem_port_arb_ctrl.sv
// Bench for mem_port_arb_ctrl: directed scenarios then random transactions,
// with a round-robin arbiter stub and a transaction-level expectation model.
module tb_mem_port_arb_ctrl;
    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic [N-1:0]    port_req_valid, port_req_ready, port_req_we;
    logic [N-1:0]    port_rsp_valid, arb_req, arb_grant;
    logic [N*AW-1:0] port_req_addr;
    logic [N*DW-1:0] port_req_wdata;
    logic [N*SW-1:0] port_req_wstrb;
    logic [DW-1:0]   port_rsp_rdata;

    logic [AW-1:0] addr_a  [N];
    logic          we_a    [N];
    logic [DW-1:0] wdata_a [N];
    logic [SW-1:0] wstrb_a [N];

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign port_req_addr[g*AW +: AW]  = addr_a[g];
        assign port_req_we[g]             = we_a[g];
        assign port_req_wdata[g*DW +: DW] = wdata_a[g];
        assign port_req_wstrb[g*SW +: SW] = wstrb_a[g];
    end

    mem_port_if #(.AW(AW), .DW(DW)) mem_if ();

    mem_port_arb_ctrl #(.N(N), .AW(AW), .DW(DW)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .port_req_valid (port_req_valid),
        .port_req_ready (port_req_ready),
        .port_req_addr  (port_req_addr),
        .port_req_we    (port_req_we),
        .port_req_wdata (port_req_wdata),
        .port_req_wstrb (port_req_wstrb),
        .port_rsp_valid (port_rsp_valid),
        .port_rsp_rdata (port_rsp_rdata),
        .arb_req        (arb_req),
        .arb_grant      (arb_grant),
        .mem            (mem_if)
    );

    // Round-robin arbiter stub: pointer moves only when a grant is taken.
    int   rr_last;
    logic arb_found;
    always_comb begin
        arb_grant = '0;
        arb_found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!arb_found && arb_req[(rr_last + k) % N]) begin
                arb_grant[(rr_last + k) % N] = 1'b1;
                arb_found = 1'b1;
            end
        end
    end
    always @(posedge clk) begin
        if (!rstn) rr_last <= N - 1;
        else for (int i = 0; i < N; i++) if (port_req_ready[i]) rr_last <= i;
    end

    int            vectors = 0;
    int            miscompares = 0;
    logic [N-1:0]  pend_rsp = '0;
    logic [DW-1:0] exp_rdata = '0;
    int            last_owner = N - 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    task automatic idle_cycle(input bit spur);
        port_req_valid = '0;
        mem_if.mem_req_ready = 1'b0;
        mem_if.mem_rsp_valid = spur;
        mem_if.mem_rsp_rdata = $urandom;
        settle();
        chk("idle_rsp_valid", port_rsp_valid, pend_rsp);
        chk("idle_rsp_rdata", port_rsp_rdata, exp_rdata);
        chk("idle_req_ready", port_req_ready, 0);
        chk("idle_mem_valid", mem_if.mem_req_valid, 0);
        pend_rsp = '0;
        adv();
        mem_if.mem_rsp_valid = 1'b0;
    endtask

    // Runs one transaction; its first cycle may coincide with the previous response pulse.
    task automatic run_txn(input logic [N-1:0] vld, input int rdy_dly, input int rsp_dly,
                           input logic [DW-1:0] rdata, input bit spur);
        int            owner;
        logic [N-1:0]  oh;
        logic [AW-1:0] e_addr;
        logic          e_we;
        logic [DW-1:0] e_wdata;
        logic [SW-1:0] e_wstrb;
        owner = pick(vld, last_owner);
        oh = '0;
        oh[owner] = 1'b1;
        e_addr = addr_a[owner];
        e_we = we_a[owner];
        e_wdata = wdata_a[owner];
        e_wstrb = wstrb_a[owner];

        port_req_valid = vld;
        mem_if.mem_req_ready = 1'b0;
        mem_if.mem_rsp_valid = spur;
        mem_if.mem_rsp_rdata = $urandom;
        settle();
        chk("accept_rsp_valid", port_rsp_valid, pend_rsp);
        chk("accept_rsp_rdata", port_rsp_rdata, exp_rdata);
        chk("accept_req_ready", port_req_ready, oh);
        chk("accept_arb_req", arb_req, vld);
        chk("accept_mem_valid", mem_if.mem_req_valid, 0);
        pend_rsp = '0;
        adv();

        port_req_valid = vld & ~oh;
        addr_a[owner] = $urandom;
        we_a[owner] = ~e_we;
        wdata_a[owner] = $urandom;
        wstrb_a[owner] = ~e_wstrb;
        for (int d = 0; d <= rdy_dly; d++) begin
            mem_if.mem_req_ready = (d == rdy_dly);
            mem_if.mem_rsp_valid = spur;
            mem_if.mem_rsp_rdata = $urandom;
            settle();
            chk("issue_mem_valid", mem_if.mem_req_valid, 1);
            chk("issue_addr", mem_if.mem_req_addr, e_addr);
            chk("issue_we", mem_if.mem_req_we, e_we);
            chk("issue_wdata", mem_if.mem_req_wdata, e_wdata);
            chk("issue_wstrb", mem_if.mem_req_wstrb, e_wstrb);
            chk("issue_arb_req", arb_req, 0);
            chk("issue_req_ready", port_req_ready, 0);
            chk("issue_rsp_valid", port_rsp_valid, 0);
            adv();
        end

        mem_if.mem_req_ready = 1'b0;
        for (int d = 0; d <= rsp_dly; d++) begin
            mem_if.mem_rsp_valid = (d == rsp_dly);
            mem_if.mem_rsp_rdata = (d == rsp_dly) ? rdata : DW'($urandom);
            settle();
            chk("wait_mem_valid", mem_if.mem_req_valid, 0);
            chk("wait_arb_req", arb_req, 0);
            chk("wait_rsp_valid", port_rsp_valid, 0);
            chk("wait_rsp_rdata", port_rsp_rdata, exp_rdata);
            adv();
        end
        mem_if.mem_rsp_valid = 1'b0;
        pend_rsp = oh;
        exp_rdata = rdata;
        last_owner = owner;
    endtask

    initial begin
        rstn = 1'b0;
        port_req_valid = '0;
        mem_if.mem_req_ready = 1'b0;
        mem_if.mem_rsp_valid = 1'b0;
        mem_if.mem_rsp_rdata = '0;
        for (int i = 0; i < N; i++) begin
            addr_a[i] = '0; we_a[i] = 1'b0; wdata_a[i] = '0; wstrb_a[i] = '0;
        end
        adv();
        adv();
        settle();
        chk("rst_rsp_valid", port_rsp_valid, 0);
        chk("rst_rsp_rdata", port_rsp_rdata, 0);
        chk("rst_mem_valid", mem_if.mem_req_valid, 0);
        chk("rst_req_ready", port_req_ready, 0);
        adv();
        rstn = 1'b1;

        // Single read from port 0, zero-wait memory.
        addr_a[0] = 32'h100; we_a[0] = 1'b0; wdata_a[0] = '0; wstrb_a[0] = 4'hF;
        run_txn(2'b01, 0, 0, 32'hDEADBEEF, 1'b0);
        idle_cycle(1'b0);

        // Both ports requesting continuously, responses overlapping the next accept.
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < N; i++) begin
                addr_a[i] = 32'h1000 * (t + 1) + 32'h10 * i;
                we_a[i] = i[0];
                wdata_a[i] = 32'hA5A50000 + t * 4 + i;
                wstrb_a[i] = 4'hF;
            end
            run_txn(2'b11, 0, t, 32'hC0DE0000 + t, 1'b0);
        end
        idle_cycle(1'b0);

        // Port 1 write held under five cycles of backpressure.
        addr_a[1] = 32'h200; we_a[1] = 1'b1; wdata_a[1] = 32'h12345678; wstrb_a[1] = 4'b0011;
        run_txn(2'b10, 5, 1, 32'h0BADF00D, 1'b0);
        idle_cycle(1'b0);

        // Spurious memory responses in IDLE and ISSUE.
        idle_cycle(1'b1);
        addr_a[0] = 32'h440; we_a[0] = 1'b0; wstrb_a[0] = 4'hF;
        run_txn(2'b01, 3, 0, 32'h55AA55AA, 1'b1);
        idle_cycle(1'b1);

        // Reset while waiting; the late response must be ignored.
        addr_a[0] = 32'h300; we_a[0] = 1'b0;
        port_req_valid = 2'b01;
        settle();
        chk("rw_req_ready", port_req_ready, 2'b01);
        adv();
        port_req_valid = '0;
        mem_if.mem_req_ready = 1'b1;
        settle();
        chk("rw_issue_valid", mem_if.mem_req_valid, 1);
        adv();
        mem_if.mem_req_ready = 1'b0;
        rstn = 1'b0;
        settle();
        chk("rw_wait_valid", mem_if.mem_req_valid, 0);
        adv();
        rstn = 1'b1;
        mem_if.mem_rsp_valid = 1'b1;
        mem_if.mem_rsp_rdata = 32'hBAD0BAD0;
        settle();
        chk("rw_post_mem_valid", mem_if.mem_req_valid, 0);
        chk("rw_post_rsp_valid", port_rsp_valid, 0);
        chk("rw_post_rsp_rdata", port_rsp_rdata, 0);
        adv();
        mem_if.mem_rsp_valid = 1'b0;
        settle();
        chk("rw_late_rsp_valid", port_rsp_valid, 0);
        chk("rw_late_rsp_rdata", port_rsp_rdata, 0);
        adv();
        pend_rsp = '0;
        exp_rdata = '0;
        last_owner = N - 1;
        addr_a[0] = 32'h310; we_a[0] = 1'b1; wdata_a[0] = 32'hFACE0001; wstrb_a[0] = 4'b1000;
        run_txn(2'b01, 0, 0, 32'h600D600D, 1'b0);
        idle_cycle(1'b0);

        // Random traffic.
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < N; i++) begin
                addr_a[i] = $urandom;
                we_a[i] = 1'($urandom_range(0, 1));
                wdata_a[i] = $urandom;
                wstrb_a[i] = 4'($urandom_range(0, 15));
            end
            run_txn(N'($urandom_range(1, 3)), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) idle_cycle(1'($urandom_range(0, 1)));
        end
        idle_cycle(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
